vga_sync_gen: RTL

- Free-running VGA timing transmitter: produces HSync/VSync pulses plus aligned column/row counts and an active-video flag.
- Opposite end of the sync-to-count receiver path: it generates the i_HSync/i_VSync that the Frogg game top consumes.
- Sits at the top of the video chain, driven by the pixel clock or by a pixel-rate enable.
- Default timing is 640x480 @ 60 Hz (800x525 total).

---
 rtl/vga_sync_gen.sv | 109 ++++++++++
 1 files changed

// File: rtl/vga_sync_gen.sv
// vga_sync_gen: free-running VGA timing generator with registered, skew-free sync/count/active decode.
// Optional: define VGA_SYNC_FRAME_COUNT_EN to add an 8-bit wrapped-frame counter on o_Frame_Count.
module vga_sync_gen #(
    parameter int   c_TOTAL_COLS    = 800,
    parameter int   c_TOTAL_ROWS    = 525,
    parameter int   c_ACTIVE_COLS   = 640,
    parameter int   c_ACTIVE_ROWS   = 480,
    parameter int   c_H_FRONT_PORCH = 16,
    parameter int   c_H_SYNC        = 96,
    parameter int   c_V_FRONT_PORCH = 10,
    parameter int   c_V_SYNC        = 2,
    parameter logic c_SYNC_ACTIVE   = 1'b0
) (
    input  logic       i_Clk,
    input  logic       i_Rst_L,
    input  logic       i_Pix_En,
    output logic       o_HSync,
    output logic       o_VSync,
    output logic [9:0] o_Col_Count,
    output logic [9:0] o_Row_Count,
    output logic       o_Active,
`ifdef VGA_SYNC_FRAME_COUNT_EN
    output logic [7:0] o_Frame_Count,
`endif
    output logic       o_Frame_Start
);
    localparam logic [9:0] COL_LAST = 10'(c_TOTAL_COLS - 1);
    localparam logic [9:0] ROW_LAST = 10'(c_TOTAL_ROWS - 1);
    localparam logic [9:0] COL_ACT  = 10'(c_ACTIVE_COLS);
    localparam logic [9:0] ROW_ACT  = 10'(c_ACTIVE_ROWS);
    localparam logic [9:0] HS_BEG   = 10'(c_ACTIVE_COLS + c_H_FRONT_PORCH);
    localparam logic [9:0] HS_END   = 10'(c_ACTIVE_COLS + c_H_FRONT_PORCH + c_H_SYNC - 1);
    localparam logic [9:0] VS_BEG   = 10'(c_ACTIVE_ROWS + c_V_FRONT_PORCH);
    localparam logic [9:0] VS_END   = 10'(c_ACTIVE_ROWS + c_V_FRONT_PORCH + c_V_SYNC - 1);

    typedef enum logic {PRIMED, RUN} state_t;

    state_t     state_q, state_d;
    logic [9:0] col_q, col_d, row_q, row_d;
    logic       hsync_q, hsync_d, vsync_q, vsync_d;
    logic       active_q, active_d, fs_q, fs_d;
    logic       col_wrap, wrap;

    always_comb begin
        state_d  = state_q;
        col_d    = col_q;
        row_d    = row_q;
        fs_d     = 1'b0;
        col_wrap = col_q == COL_LAST;
        wrap     = 1'b0;
        if (i_Pix_En) begin
            if (state_q == PRIMED) begin
                col_d   = '0;
                row_d   = '0;
                fs_d    = 1'b1;
                state_d = RUN;
            end else begin
                wrap  = col_wrap && (row_q == ROW_LAST);
                col_d = col_wrap ? '0 : col_q + 10'd1;
                row_d = !col_wrap ? row_q : (row_q == ROW_LAST) ? '0 : row_q + 10'd1;
                fs_d  = wrap;
            end
        end
        // Decode the next position so every output register describes the same pixel.
        hsync_d  = !i_Pix_En ? hsync_q : (col_d >= HS_BEG && col_d <= HS_END) ? c_SYNC_ACTIVE : ~c_SYNC_ACTIVE;
        vsync_d  = !i_Pix_En ? vsync_q : (row_d >= VS_BEG && row_d <= VS_END) ? c_SYNC_ACTIVE : ~c_SYNC_ACTIVE;
        active_d = !i_Pix_En ? active_q : (col_d < COL_ACT) && (row_d < ROW_ACT);
    end

    always_ff @(posedge i_Clk) begin
        if (!i_Rst_L) begin
            state_q  <= PRIMED;
            col_q    <= '0;
            row_q    <= '0;
            hsync_q  <= ~c_SYNC_ACTIVE;
            vsync_q  <= ~c_SYNC_ACTIVE;
            active_q <= 1'b0;
            fs_q     <= 1'b0;
        end else begin
            state_q  <= state_d;
            col_q    <= col_d;
            row_q    <= row_d;
            hsync_q  <= hsync_d;
            vsync_q  <= vsync_d;
            active_q <= active_d;
            fs_q     <= fs_d;
        end
    end

`ifdef VGA_SYNC_FRAME_COUNT_EN
    logic [7:0] fc_q, fc_d;

    assign fc_d = fc_q + {7'd0, wrap};

    always_ff @(posedge i_Clk) begin
        if (!i_Rst_L) fc_q <= '0;
        else          fc_q <= fc_d;
    end

    assign o_Frame_Count = fc_q;
`endif

    assign o_HSync       = hsync_q;
    assign o_VSync       = vsync_q;
    assign o_Col_Count   = col_q;
    assign o_Row_Count   = row_q;
    assign o_Active      = active_q;
    assign o_Frame_Start = fs_q;
endmodule
